// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: MIPS opcode/funct
// constants, the counter-width default and the registered payload layout.
package id_ex_stage_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] FUNCT_ADD = 6'b100000;

    // Everything that crosses ID->EX; a bubble is simply the all-zero value.
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        reg_dst;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [31:0] reg_a;
        logic [31:0] reg_b;
        logic [31:0] se_imme;
        logic [31:0] pc_add4;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID forces one bubble, unless a redirect kills ID anyway.
module hazard_detect (
    input  logic       valid_e_i,
    input  logic       mem_to_reg_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic       reg_dst_d_i,
    input  logic       mem_write_d_i,
    input  logic       branch_d_i,
    input  logic       flush_i,
    output logic       stall_o
);

    logic uses_rt_d;
    logic rt_match;

    assign uses_rt_d = reg_dst_d_i | mem_write_d_i | branch_d_i;
    assign rt_match  = (rt_e_i == rs_d_i) | (uses_rt_d & (rt_e_i == rt_d_i));

    // $0 is hardwired to zero, so a load targeting it never creates a dependence.
    assign stall_o = valid_e_i & mem_to_reg_e_i & (rt_e_i != 5'd0) & rt_match & ~flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling and
// saturating bubble/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             RegWrite_D,
    input  logic             MemtoReg_D,
    input  logic             MemWrite_D,
    input  logic             Branch_D,
    input  logic             Jump_D,
    input  logic             ALUSrc_D,
    input  logic             RegDst_D,
    input  logic [5:0]       Opcode_D,
    input  logic [5:0]       Funct_D,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       rd_D,
    input  logic [4:0]       shamt_D,
    input  logic [31:0]      regA_data_D,
    input  logic [31:0]      regB_data_D,
    input  logic [31:0]      se_imme_D,
    input  logic [31:0]      PC_add4_D,
    input  logic             Flush_in,
    output logic             RegWrite_E,
    output logic             MemtoReg_E,
    output logic             MemWrite_E,
    output logic             Branch_E,
    output logic             Jump_E,
    output logic             ALUSrc_E,
    output logic             RegDst_E,
    output logic [5:0]       Opcode_E,
    output logic [5:0]       Funct_E,
    output logic [4:0]       rs_E,
    output logic [4:0]       rt_E,
    output logic [4:0]       rd_E,
    output logic [4:0]       shamt_E,
    output logic [31:0]      regA_data_E,
    output logic [31:0]      regB_data_E,
    output logic [31:0]      se_imme_E,
    output logic [31:0]      PC_add4_E,
    output logic             valid_E,
    output logic             Stall_out,
    output logic [CNT_W-1:0] bubble_cnt_out,
    output logic [CNT_W-1:0] flush_cnt_out
);

    id_ex_t            d_bus;
    id_ex_t            ex_d, ex_q;
    logic              valid_d, valid_q;
    logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;

    assign d_bus = '{
        reg_write:  RegWrite_D,  mem_to_reg: MemtoReg_D, mem_write: MemWrite_D,
        branch:     Branch_D,    jump:       Jump_D,     alu_src:   ALUSrc_D,
        reg_dst:    RegDst_D,    opcode:     Opcode_D,   funct:     Funct_D,
        rs:         rs_D,        rt:         rt_D,       rd:        rd_D,
        shamt:      shamt_D,     reg_a:      regA_data_D, reg_b:    regB_data_D,
        se_imme:    se_imme_D,   pc_add4:    PC_add4_D
    };

    hazard_detect u_hazard_detect (
        .valid_e_i      (valid_q),
        .mem_to_reg_e_i (ex_q.mem_to_reg),
        .rt_e_i         (ex_q.rt),
        .rs_d_i         (rs_D),
        .rt_d_i         (rt_D),
        .reg_dst_d_i    (RegDst_D),
        .mem_write_d_i  (MemWrite_D),
        .branch_d_i     (Branch_D),
        .flush_i        (Flush_in),
        .stall_o        (Stall_out)
    );

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        ex_d         = d_bus;
        valid_d      = 1'b1;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        if (Flush_in || Stall_out) begin
            ex_d    = '0;
            valid_d = 1'b0;
        end
        if (Stall_out && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
        if (Flush_in && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all registers update from pre-edge values.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            ex_q         <= '0;
            valid_q      <= 1'b0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            ex_q         <= ex_d;
            valid_q      <= valid_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign RegWrite_E     = ex_q.reg_write;
    assign MemtoReg_E     = ex_q.mem_to_reg;
    assign MemWrite_E     = ex_q.mem_write;
    assign Branch_E       = ex_q.branch;
    assign Jump_E         = ex_q.jump;
    assign ALUSrc_E       = ex_q.alu_src;
    assign RegDst_E       = ex_q.reg_dst;
    assign Opcode_E       = ex_q.opcode;
    assign Funct_E        = ex_q.funct;
    assign rs_E           = ex_q.rs;
    assign rt_E           = ex_q.rt;
    assign rd_E           = ex_q.rd;
    assign shamt_E        = ex_q.shamt;
    assign regA_data_E    = ex_q.reg_a;
    assign regB_data_E    = ex_q.reg_b;
    assign se_imme_E      = ex_q.se_imme;
    assign PC_add4_E      = ex_q.pc_add4;
    assign valid_E        = valid_q;
    assign bubble_cnt_out = bubble_cnt_q;
    assign flush_cnt_out  = flush_cnt_q;

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, meaning the width of the saturating bubble and flush counters.
REQ-002 Port CLOCK, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port RESET, input, 1: synchronous, active-high reset.
REQ-004 Ports RegWrite_D, MemtoReg_D, MemWrite_D, Branch_D, Jump_D, ALUSrc_D, RegDst_D, input, 1 each: decoded control bits from ID.
REQ-005 Ports Opcode_D, Funct_D, input, 6 each: opcode and funct from ID.
REQ-006 Ports rs_D, rt_D, rd_D, shamt_D, input, 5 each: instruction fields [25:21], [20:16], [15:11], [10:6].
REQ-007 Ports regA_data_D, regB_data_D, se_imme_D, PC_add4_D, input, 32 each: operands, sign-extended immediate and PC+4 from ID.
REQ-008 Port Flush_in, input, 1: EX-resolved redirect (taken branch or jump); kills the instruction in ID.
REQ-009 Each D-side control, field and data port SHALL have an _E output of identical width, carrying the registered copy.
REQ-010 Port valid_E, output, 1: the EX-stage slot holds a real instruction rather than a bubble.
REQ-011 Port Stall_out, output, 1: combinational load-use stall, to be driven into IF_ID Stall and the PC hold.
REQ-012 Ports bubble_cnt_out and flush_cnt_out, output, CNT_W each: saturating event counters.

Function
REQ-013 usesRt_D SHALL be 1 when RegDst_D, MemWrite_D or Branch_D is 1, and 0 otherwise.
REQ-014 Stall_out SHALL be 1 exactly when all of the following hold: valid_E=1; MemtoReg_E=1; rt_E!=0; (rt_E==rs_D or (usesRt_D and rt_E==rt_D)); Flush_in=0.
REQ-015 Stall_out SHALL depend only on current _E registers and current _D inputs, with no registered delay.
REQ-016 On each edge with RESET=0, if Flush_in=1 or Stall_out=1, the register SHALL load a bubble: all _E outputs 0 and valid_E=0.
REQ-017 Otherwise the register SHALL load every _D input into its _E output and set valid_E=1.
REQ-018 Latency from a D input to the matching _E output SHALL be exactly one cycle.
REQ-019 A bubble SHALL have RegWrite_E, MemWrite_E, Branch_E and Jump_E equal to 0, so it has no architectural effect.
REQ-020 Flush_in SHALL take priority over a load-use condition in the same cycle; only flush_cnt_out increments.
REQ-021 bubble_cnt_out SHALL increment by 1 on each edge where Stall_out=1.
REQ-022 flush_cnt_out SHALL increment by 1 on each edge where Flush_in=1.
REQ-023 Both counters SHALL saturate at all-ones and never wrap.
REQ-024 A stalled instruction SHALL be re-presented by ID on the next cycle, find valid_E=0, and pass through; one bubble SHALL be inserted per load-use pair.
REQ-025 Back-to-back lw followed by a dependent instruction SHALL stall only the dependent instruction, once.
REQ-026 Register $0 SHALL never cause a stall.

Reset
REQ-027 When RESET=1 at an edge, all _E outputs, valid_E and both counters SHALL become 0, regardless of Flush_in and Stall_out.
REQ-028 While RESET=1, Stall_out SHALL be 0, because valid_E=0.
REQ-029 Reset asserted mid-stall SHALL discard the pending bubble; the first instruction after release SHALL be loaded normally.

Structure
REQ-030 Opcode and funct constants (LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, JAL 000011) SHALL live in a shared package, together with the CNT_W default.
REQ-031 The load-use comparator SHALL be one sub-module, hazard_detect, which is purely combinational and produces Stall_out.
REQ-032 The pipeline register and the counters SHALL reside in id_ex_stage.

Verification
REQ-033 Scenario lw $8,0($9) then add $10,$8,$11 -> Stall_out=1 for one cycle; the cycle after shows valid_E=0 with all _E outputs 0; the add reaches EX on the next cycle; bubble_cnt_out=1.
REQ-034 Scenario lw $8 then sw $8,4($12) -> stall because usesRt_D; lw $8 then addi $8,$8,1 (rs match) -> stall; lw $0 then add $1,$0,$0 -> no stall.
REQ-035 Scenario load-use condition with Flush_in=1 in the same cycle -> Stall_out=0; bubble loaded; flush_cnt_out=1; bubble_cnt_out unchanged.
REQ-036 Scenario RESET=1 asserted during a stall cycle with regA_data_D=0xDEADBEEF -> next cycle all _E outputs are 0 and both counters are 0.
REQ-037 Scenario CNT_W=4 with 20 consecutive flushes -> flush_cnt_out holds at 0xF.
REQ-038 Scenario a random non-hazard stream of 100 instructions -> every _E output equals its _D value one cycle later; valid_E=1 throughout.
